// File: rtl/handshake_pkg.sv
// Shared definitions for the elastic-handshake fabric: the default constant
// and an elaboration-time clog2 helper used for index widths.
package handshake_pkg;

  localparam logic [31:0] HS_CONST_DEFAULT = 32'h0001F7F8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first set request at or above
// ptr (wrapping), returning it one-hot, encoded, and an any-request flag.
module rr_priority_picker
  import handshake_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ <= 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int unsigned          pos;

  // Doubling the vector turns the wrap-around scan into a plain right shift.
  always_comb begin
    dbl     = {req, req};
    rot     = NUM_REQ'(dbl >> ptr);
    any     = |req;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pos   = 32'(ptr) + j;
        if (pos >= NUM_REQ) begin
          pos = pos - NUM_REQ;
        end
        gnt     = NUM_REQ'(1) << pos;
        gnt_idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter turning granted control tokens into per-requester
// constants, tagged with the requester index, held in a one-entry slot.
module handshake_constant_arbiter
  import handshake_pkg::*;
#(
  parameter int unsigned                       NUM_REQ    = 4,
  parameter int unsigned                       DATA_WIDTH = 32,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0]     CONST_VEC  =
    {NUM_REQ{DATA_WIDTH'(HS_CONST_DEFAULT)}},
  parameter int unsigned                       IDX_W      =
    (NUM_REQ <= 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  any;
  logic                  slot_free;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] outs_nxt;
  logic [IDX_W-1:0]      outs_index_nxt;
  logic                  outs_valid_nxt;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (ctrl_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Slot accepts a new token when empty or being drained this cycle.
  assign slot_free  = !outs_valid || outs_ready;
  assign xfer       = slot_free && any && !rst;
  assign ctrl_ready = xfer ? gnt : '0;

  always_comb begin
    outs_nxt       = outs;
    outs_index_nxt = outs_index;
    outs_valid_nxt = outs_valid;
    ptr_nxt        = ptr;
    if (xfer) begin
      outs_nxt       = DATA_WIDTH'(CONST_VEC >> (32'(gnt_idx) * DATA_WIDTH));
      outs_index_nxt = gnt_idx;
      outs_valid_nxt = 1'b1;
      if (32'(gnt_idx) >= NUM_REQ - 1) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = gnt_idx + IDX_W'(1);
      end
    end else if (outs_ready) begin
      outs_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs       <= '0;
      outs_index <= '0;
      outs_valid <= 1'b0;
      ptr        <= '0;
    end else begin
      outs       <= outs_nxt;
      outs_index <= outs_index_nxt;
      outs_valid <= outs_valid_nxt;
      ptr        <= ptr_nxt;
    end
  end

endmodule
